// File: rtl/seg7_scan_controller.sv
// Four-digit time-multiplexed 7-segment scanner: rotates one shared decoder over
// four anodes, with an optional all-dark blanking gap between digits.
module seg7_scan_controller #(
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit_en,
  input  logic       freeze,
  output logic [3:0] hex,
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       anode_q, anode_d;
  logic [3:0]       hex_q, hex_d;
  logic             tick_q, tick_d;

  function automatic logic [3:0] anode_drive(input state_t st, input logic [1:0] sel,
                                             input logic [3:0] en);
    logic [3:0] a;
    a = 4'b1111;
    if (st == ST_SHOW && en[sel]) a[sel] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] pick_digit(input logic [1:0] sel, input logic [3:0] d0,
                                            input logic [3:0] d1, input logic [3:0] d2,
                                            input logic [3:0] d3);
    case (sel)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  // Outputs are computed from the next state so anode/hex/digit_sel change on
  // the same edge that moves the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          if (!freeze) begin
            sel_d  = sel_q + 2'd1;
            tick_d = (sel_q == 2'd3);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
    anode_d = anode_drive(state_d, sel_d, digit_en);
    hex_d   = pick_digit(sel_d, digit0, digit1, digit2, digit3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1111;
      hex_q   <= 4'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      hex_q   <= hex_d;
      tick_q  <= tick_d;
    end
  end

  assign hex        = hex_q;
  assign anode      = anode_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: one instance with a blanking gap, one without,
// both compared every cycle against a slot-position reference model.
module tb_seg7_scan_controller;

  localparam int SHOW = 4;
  localparam int BLK_A = 2;
  localparam int BLK_B = 0;

  logic       clk;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] digit_en;
  logic       freeze;

  logic [3:0] a_hex, a_anode, b_hex, b_anode;
  logic [1:0] a_sel, b_sel;
  logic       a_tick, b_tick;

  seg7_scan_controller #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLK_A)) dut_a (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .digit_en(digit_en), .freeze(freeze), .hex(a_hex), .anode(a_anode),
    .digit_sel(a_sel), .frame_tick(a_tick)
  );

  seg7_scan_controller #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLK_B)) dut_b (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .digit_en(digit_en), .freeze(freeze), .hex(b_hex), .anode(b_anode),
    .digit_sel(b_sel), .frame_tick(b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the current slot (blank cycles first,
  // then show cycles) plus the slot's digit index, per instance.
  int         blk[2] = '{BLK_A, BLK_B};
  int         m_pos[2];
  int         m_sel[2];
  bit         m_post[2];
  logic [3:0] e_anode[2];
  logic [3:0] e_hex[2];
  logic [1:0] e_sel[2];
  logic       e_tick[2];

  function automatic logic [3:0] dig(input int k);
    case (k)
      0:       return digit0;
      1:       return digit1;
      2:       return digit2;
      default: return digit3;
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pos[i] = 0; m_sel[i] = 0; m_post[i] = 1'b1;
        e_anode[i] = 4'b1111; e_hex[i] = 4'd0; e_sel[i] = 2'd0; e_tick[i] = 1'b0;
      end else begin
        logic [3:0] onehot;
        e_tick[i] = 1'b0;
        if (m_post[i] && blk[i] == 0) begin
          m_post[i] = 1'b0;
          m_pos[i]  = 0;
        end else begin
          m_post[i] = 1'b0;
          m_pos[i]++;
          if (m_pos[i] == blk[i] + SHOW) begin
            m_pos[i] = 0;
            if (!freeze) begin
              e_tick[i] = (m_sel[i] == 3);
              m_sel[i]  = (m_sel[i] + 1) % 4;
            end
          end
        end
        onehot     = 4'b0001 << m_sel[i];
        e_anode[i] = (m_pos[i] >= blk[i] && digit_en[m_sel[i]]) ? ~onehot : 4'b1111;
        e_hex[i]   = dig(m_sel[i]);
        e_sel[i]   = 2'(m_sel[i]);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a_anode", 32'(a_anode), 32'(e_anode[0]));
    check("a_hex",   32'(a_hex),   32'(e_hex[0]));
    check("a_sel",   32'(a_sel),   32'(e_sel[0]));
    check("a_tick",  32'(a_tick),  32'(e_tick[0]));
    check("b_anode", 32'(b_anode), 32'(e_anode[1]));
    check("b_hex",   32'(b_hex),   32'(e_hex[1]));
    check("b_sel",   32'(b_sel),   32'(e_sel[1]));
    check("b_tick",  32'(b_tick),  32'(e_tick[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int ta, tb, n;
    reset = 1'b1; freeze = 1'b0; digit_en = 4'b1111;
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'h3; digit3 = 4'h4;

    // Reset held 3 cycles, then two full frames of rotation.
    for (int k = 0; k < 3; k++) cycle();
    check("rst_anode", 32'(a_anode), 32'hF);
    check("rst_hex",   32'(a_hex),   32'h0);
    reset = 1'b0;
    ta = 0; tb = 0;
    for (int k = 0; k < 48; k++) begin
      cycle();
      ta += int'(a_tick);
      tb += int'(b_tick);
    end
    check("ticks_a_48", 32'(ta), 32'd2);
    check("ticks_b_48", 32'(tb), 32'd2);

    // Disabled digit 2.
    digit_en = 4'b1011;
    for (int k = 0; k < 30; k++) cycle();
    digit_en = 4'b1111;

    // Freeze during slot 1.
    n = 0;
    while (n < 100 && !(m_sel[0] == 1 && m_pos[0] == BLK_A)) begin cycle(); n++; end
    check("reach_slot1", 32'(m_sel[0] == 1 && m_pos[0] == BLK_A), 32'd1);
    freeze = 1'b1;
    for (int k = 0; k < 18; k++) begin
      cycle();
      check("frz_sel", 32'(a_sel), 32'd1);
    end
    freeze = 1'b0;
    for (int k = 0; k < 12; k++) cycle();

    // Reset in the 3rd show cycle of slot 2.
    n = 0;
    while (n < 100 && !(m_sel[0] == 2 && m_pos[0] == BLK_A + 2)) begin cycle(); n++; end
    check("reach_slot2", 32'(m_sel[0] == 2 && m_pos[0] == BLK_A + 2), 32'd1);
    reset = 1'b1;
    cycle();
    check("midrst_anode", 32'(a_anode), 32'hF);
    check("midrst_sel",   32'(a_sel),   32'd0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) cycle();

    // Live digit change mid-slot 0.
    n = 0;
    while (n < 100 && !(m_sel[0] == 0 && m_pos[0] == BLK_A + 1)) begin cycle(); n++; end
    check("reach_slot0", 32'(m_sel[0] == 0 && m_pos[0] == BLK_A + 1), 32'd1);
    digit0 = 4'hA;
    cycle();
    check("live_hex",   32'(a_hex),   32'hA);
    check("live_anode", 32'(a_anode), 32'hE);
    for (int k = 0; k < 10; k++) cycle();

    // Random digits, enables, freeze and occasional reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: digit0 = 4'($urandom);
          1: digit1 = 4'($urandom);
          2: digit2 = 4'($urandom);
          default: digit3 = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      freeze = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-division scheduler that shares the board's single hex-to-7-segment decoder and its four anode lines among four 4-bit display sources, for example detector state, mode and match count. The block sits between the status datapath and the `hex_to7segment` decoder, replacing the fixed anode pattern `4'b1110`. It rotates through the digits at a programmable refresh rate and inserts an all-off blanking gap between digits to suppress ghosting. It runs on the on-board clock, not the step clock, so the display stays live while the detector is single-stepped.

## Interface
Parameters:
- `SHOW_CYCLES`, default 100000: clock cycles each digit is driven (1 ms at 100 MHz); must be ≥ 1.
- `BLANK_CYCLES`, default 1000: clock cycles of all-anodes-off between digits; 0 disables blanking.

Ports:
- `clk`  in  1  on-board clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit0`, `digit1`, `digit2`, `digit3`  in  4 each  hex nibble for anode 0–3 (anode 0 is the rightmost digit).
- `digit_en`  in  4  per-digit enable; bit i = 0 keeps anode i dark during its slot.
- `freeze`  in  1  hold the current digit (no rotation) while high; used for debug and test.
- `hex`  out  4  nibble to the decoder, equal to the selected digit's input.
- `anode`  out  4  active-low anode drive (0 = digit on).
- `digit_sel`  out  2  index of the current slot.
- `frame_tick`  out  1  one-cycle pulse at the end of slot 3.

## Operation
- Two-state FSM, `BLANK` and `SHOW`, with one slot counter and a 2-bit `digit_sel`. All outputs are registered.
- Reset values: state `BLANK`, counter 0, `digit_sel` = 0, `anode` = 4'b1111, `hex` = 0, `frame_tick` = 0. Reset overrides every other input in the same cycle, including reset asserted mid-slot.
- `BLANK` state:
  - `anode` = 4'b1111.
  - Counter counts to `BLANK_CYCLES`−1, then the FSM enters `SHOW` with the counter cleared.
  - If `BLANK_CYCLES` = 0, the FSM goes from `SHOW` straight back to `SHOW` with the new `digit_sel`. `BLANK` is then only the one-cycle post-reset state.
- `SHOW` state:
  - `anode` = all ones except bit `digit_sel`, which is 0 when `digit_en[digit_sel]` = 1.
  - If `digit_en[digit_sel]` = 0, `anode` = 4'b1111.
  - Counter counts to `SHOW_CYCLES`−1, then the FSM leaves `SHOW`.
- At slot end (exit from `SHOW`):
  - With `freeze` = 0: `digit_sel` ← `digit_sel`+1 mod 4 (3 wraps to 0), and `frame_tick` pulses for one cycle if the old `digit_sel` was 3.
  - With `freeze` = 1: `digit_sel` holds and `frame_tick` stays 0. The blanking gap and slot timing are unchanged.
- `hex` is a registered copy of the digit selected by `digit_sel`, updated every cycle in both states. It therefore tracks live changes of the digit inputs with one cycle of latency.
- A disabled digit still consumes its full slot, so the frame period stays constant.
- `digit_en` changes take effect on `anode` in the next cycle, including mid-slot.
- `freeze` is sampled only at slot end.

## Timing
- Slot = `BLANK_CYCLES` + `SHOW_CYCLES` cycles. Frame = 4 × slot.
- After reset deassertion, the first `SHOW` of digit 0 begins `BLANK_CYCLES` cycles later, or 1 cycle later when `BLANK_CYCLES` = 0.
- Latencies:
  - Digit input to `hex`: 1 cycle.
  - `digit_en` to `anode`: 1 cycle.
  - State change to `anode`: `anode` is updated in the same edge that enters the new state.
- `digit_sel` changes on the edge that leaves `SHOW`, which is the same edge that raises `frame_tick`. `frame_tick` is high for exactly that following cycle.
- No two anode bits are ever low in the same cycle.

## Test plan
All scenarios use `SHOW_CYCLES` = 4 and `BLANK_CYCLES` = 2.
- Reset, then rotation:
  - Stimulus: hold `reset` for 3 cycles; `digit0..3` = 1, 2, 3, 4; `digit_en` = 4'b1111.
  - Response: during reset `anode` = 1111 and `hex` = 0. After release, `anode` follows 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, then repeats. `hex` reads 1, 2, 3, 4 across the four digits. `frame_tick` pulses once per 24 cycles.
- Disabled digit:
  - Stimulus: `digit_en` = 4'b1011.
  - Response: slot 2 shows `anode` = 1111 for all 6 cycles; the other slots are unchanged; the frame period stays 24 cycles.
- Freeze:
  - Stimulus: assert `freeze` during slot 1.
  - Response: `digit_sel` stays 1; `anode` alternates 1111×2 and 1101×4; `frame_tick` stays 0. After `freeze` is released, the sequence resumes at slot 2.
- No blanking:
  - Stimulus: `BLANK_CYCLES` = 0.
  - Response: `anode` goes 1110×4, 1101×4, 1011×4, 0111×4 with no 1111 gaps after the first cycle; `frame_tick` pulses every 16 cycles.
- Reset mid-slot:
  - Stimulus: assert `reset` in the 3rd `SHOW` cycle of slot 2.
  - Response: the next cycle shows `anode` = 1111 and `digit_sel` = 0; timing restarts as in the first scenario.
- Live data:
  - Stimulus: change `digit0` from 1 to A mid-slot 0.
  - Response: `hex` = A one cycle later, while `anode` is unchanged.
